// File: rtl/psram_ram_arb.sv
// Round-robin arbiter that serialises the PSRAM engine port (P) and the CPU buffer port (C)
// onto one single-port synchronous SRAM. Each grant runs IDLE -> CMD -> WAIT -> ACK.
module psram_ram_arb #(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          p_wr_req,
  input  logic          p_rd_req,
  input  logic [31:0]   p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_wr_ack,
  output logic          p_rd_ack,
  output logic [DW-1:0] p_rdata,
  input  logic          c_wr_req,
  input  logic          c_rd_req,
  input  logic [31:0]   c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_wr_ack,
  output logic          c_rd_ack,
  output logic [DW-1:0] c_rdata,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic          oor_err
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, ACK} state_e;

  state_e        state_q, state_d;
  logic          port_c_q, port_c_d;   // granted port: 0 = P, 1 = C
  logic          wr_q, wr_d;
  logic          oor_q, oor_d;         // current transfer is out of range
  logic          last_c_q, last_c_d;   // last grant went to C
  logic          cs_q, cs_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] p_rdata_q, p_rdata_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic          oor_err_q, oor_err_d;

  logic          p_req, c_req, grant_c;
  logic [31:0]   sel_addr;

  always_comb begin
    state_d   = state_q;
    port_c_d  = port_c_q;
    wr_d      = wr_q;
    oor_d     = oor_q;
    last_c_d  = last_c_q;
    cs_d      = cs_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    p_rdata_d = p_rdata_q;
    c_rdata_d = c_rdata_q;
    oor_err_d = oor_err_q;
    p_req     = p_wr_req | p_rd_req;
    c_req     = c_wr_req | c_rd_req;
    // C wins only when P is idle or P held the previous grant
    grant_c   = c_req & (~p_req | ~last_c_q);
    sel_addr  = grant_c ? c_addr : p_addr;

    case (state_q)
      IDLE: begin
        if (p_req | c_req) begin
          state_d  = CMD;
          port_c_d = grant_c;
          last_c_d = grant_c;
          wr_d     = grant_c ? c_wr_req : p_wr_req;
          oor_d    = |sel_addr[31:AW];
          cs_d     = ~(|sel_addr[31:AW]);
          we_d     = (grant_c ? c_wr_req : p_wr_req) & ~(|sel_addr[31:AW]);
          addr_d   = sel_addr[AW-1:0];
          wdata_d  = grant_c ? c_wdata : p_wdata;
        end
      end
      CMD: begin
        cs_d    = 1'b0;
        we_d    = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!wr_q) begin
          if (port_c_q) c_rdata_d = oor_q ? '0 : sram_rdata;
          else          p_rdata_d = oor_q ? '0 : sram_rdata;
        end
        oor_err_d = oor_err_q | oor_q;
        state_d   = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      port_c_q  <= 1'b0;
      wr_q      <= 1'b0;
      oor_q     <= 1'b0;
      last_c_q  <= 1'b1;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      p_rdata_q <= '0;
      c_rdata_q <= '0;
      oor_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      port_c_q  <= port_c_d;
      wr_q      <= wr_d;
      oor_q     <= oor_d;
      last_c_q  <= last_c_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      p_rdata_q <= p_rdata_d;
      c_rdata_q <= c_rdata_d;
      oor_err_q <= oor_err_d;
    end
  end

  assign p_wr_ack   = (state_q == ACK) & ~port_c_q &  wr_q;
  assign p_rd_ack   = (state_q == ACK) & ~port_c_q & ~wr_q;
  assign c_wr_ack   = (state_q == ACK) &  port_c_q &  wr_q;
  assign c_rd_ack   = (state_q == ACK) &  port_c_q & ~wr_q;
  assign p_rdata    = p_rdata_q;
  assign c_rdata    = c_rdata_q;
  assign sram_cs    = cs_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign oor_err    = oor_err_q;

endmodule

// File: tb/tb_psram_ram_arb.sv
// Directed bench for psram_ram_arb: per-port expectation queues filled when a request is
// driven and drained by a monitor on every ack; latency and arbitration order checked inline.
module tb_psram_ram_arb;
  localparam int AW = 15;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          p_wr_req = 1'b0, p_rd_req = 1'b0;
  logic [31:0]   p_addr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic          p_wr_ack, p_rd_ack;
  logic [DW-1:0] p_rdata;
  logic          c_wr_req = 1'b0, c_rd_req = 1'b0;
  logic [31:0]   c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          c_wr_ack, c_rd_ack;
  logic [DW-1:0] c_rdata;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          oor_err;

  always #5 clk = ~clk;

  psram_ram_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .p_wr_req(p_wr_req), .p_rd_req(p_rd_req), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_wr_ack(p_wr_ack), .p_rd_ack(p_rd_ack), .p_rdata(p_rdata),
    .c_wr_req(c_wr_req), .c_rd_req(c_rd_req), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_wr_ack(c_wr_ack), .c_rd_ack(c_rd_ack), .c_rdata(c_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .oor_err(oor_err)
  );

  // Synchronous single-port SRAM, one-cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] data;
  } exp_t;

  exp_t        p_q[$];
  exp_t        c_q[$];
  logic [31:0] shadow [logic [31:0]];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          cs_seen = 0;
  logic [31:0] p_last = '0, c_last = '0;
  bit          alt_on = 0, alt_prev_valid = 0, alt_prev_c = 0;
  int          p_ack_cnt = 0;
  bit          p_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Monitor: every ack pops its port's queue; one ack at a time; other port's rdata holds
  always @(negedge clk) begin
    int   nack;
    exp_t e;
    if (sram_cs) cs_seen = 1;
    if (!rstn) begin
      p_last = '0;
      c_last = '0;
    end
    nack = int'(p_wr_ack) + int'(p_rd_ack) + int'(c_wr_ack) + int'(c_rd_ack);
    if (nack != 0) begin
      chk("one_ack", 32'(nack), 1);
      if (p_wr_ack | p_rd_ack) begin
        p_ack_cnt++;
        chk("p_ack_pending", 32'(p_q.size() != 0), 1);
        if (p_q.size() != 0) begin
          e = p_q.pop_front();
          chk("p_op_wr", 32'(p_wr_ack), 32'(e.wr));
          if (p_rd_ack) chk("p_rdata", p_rdata, e.data);
        end
        if (p_rd_ack) p_last = p_rdata;
        chk("c_rdata_hold", c_rdata, c_last);
        if (alt_on) begin
          if (alt_prev_valid) chk("alternate_p", 32'(alt_prev_c), 1);
          alt_prev_valid = 1;
          alt_prev_c = 0;
        end
      end
      if (c_wr_ack | c_rd_ack) begin
        chk("c_ack_pending", 32'(c_q.size() != 0), 1);
        if (c_q.size() != 0) begin
          e = c_q.pop_front();
          chk("c_op_wr", 32'(c_wr_ack), 32'(e.wr));
          if (c_rd_ack) chk("c_rdata", c_rdata, e.data);
        end
        if (c_rd_ack) c_last = c_rdata;
        chk("p_rdata_hold", p_rdata, p_last);
        if (alt_on) begin
          if (alt_prev_valid) chk("alternate_c", 32'(alt_prev_c), 0);
          alt_prev_valid = 1;
          alt_prev_c = 1;
        end
      end
    end
  end

  // Raise a request (called just after a rising edge) and record what its ack must return
  task automatic start(input bit is_c, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] hi;
    hi = addr >> AW;
    e.wr = wr;
    e.data = '0;
    if (wr) begin
      if (hi == 0) shadow[addr] = wd;
    end else if (hi == 0) begin
      e.data = shadow[addr];
    end
    if (is_c) begin
      c_wr_req = wr; c_rd_req = !wr; c_addr = addr; c_wdata = wd; c_q.push_back(e);
    end else begin
      p_wr_req = wr; p_rd_req = !wr; p_addr = addr; p_wdata = wd; p_q.push_back(e);
    end
  endtask

  task automatic drop(input bit is_c);
    if (is_c) begin c_wr_req = 0; c_rd_req = 0; end
    else      begin p_wr_req = 0; p_rd_req = 0; end
  endtask

  // Bounded wait for the port's ack; returns just after the edge that ends the ack cycle
  task automatic wait_ack(input bit is_c, output int ack_cyc);
    bit got;
    got = 0;
    ack_cyc = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (is_c ? (c_wr_ack | c_rd_ack) : (p_wr_ack | p_rd_ack)) begin
        got = 1;
        ack_cyc = cyc;
      end
    end
    if (is_c) chk("c_ack_timeout", 32'(got), 1);
    else      chk("p_ack_timeout", 32'(got), 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 0;
    drop(0);
    drop(1);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, t1, t2, t3;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_acks", {28'd0, p_wr_ack, p_rd_ack, c_wr_ack, c_rd_ack}, 0);
    chk("rst_sram_cs_we", {30'd0, sram_cs, sram_we}, 0);
    chk("rst_sram_addr", 32'(sram_addr), 0);
    chk("rst_sram_wdata", sram_wdata, 0);
    chk("rst_p_rdata", p_rdata, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_oor_err", 32'(oor_err), 0);
    @(posedge clk); #1;

    // 1: P write then P read of the same word
    t0 = cyc;
    start(0, 1, 32'h10, 32'hA5A5_0001);
    wait_ack(0, t1);
    chk("t1_wr_latency", 32'(t1 - t0), 3);
    t0 = cyc;
    start(0, 0, 32'h10, 0);
    wait_ack(0, t1);
    chk("t1_rd_latency", 32'(t1 - t0), 3);
    drop(0);
    @(posedge clk); #1;

    // 2: simultaneous reads from reset; P re-requests while C is pending
    do_reset();
    t0 = cyc;
    fork
      begin : t2_p
        start(0, 0, 32'h10, 0);
        wait_ack(0, t1);
        start(0, 0, 32'h10, 0);
        wait_ack(0, t3);
        drop(0);
      end
      begin : t2_c
        start(1, 0, 32'h10, 0);
        wait_ack(1, t2);
        drop(1);
      end
    join
    chk("t2_p_first", 32'(t1 - t0), 3);
    chk("t2_c_second", 32'(t2 - t0), 7);
    chk("t2_p_third", 32'(t3 - t0), 11);

    // 3: P write and read together; write wins, read sees new data 4 cycles later
    t0 = cyc;
    start(0, 1, 32'h30, 32'h1234_5678);
    p_rd_req = 1;
    p_q.push_back('{wr: 1'b0, data: 32'h1234_5678});
    wait_ack(0, t1);
    p_wr_req = 0;
    wait_ack(0, t2);
    drop(0);
    chk("t3_wr_latency", 32'(t1 - t0), 3);
    chk("t3_rd_after_wr", 32'(t2 - t1), 4);

    // 4: out-of-range C read
    chk("t4_oor_before", 32'(oor_err), 0);
    cs_seen = 0;
    t0 = cyc;
    start(1, 0, 32'h0001_0000, 0);
    wait_ack(1, t1);
    drop(1);
    chk("t4_latency", 32'(t1 - t0), 3);
    chk("t4_no_cs", 32'(cs_seen), 0);
    chk("t4_oor_set", 32'(oor_err), 1);
    start(1, 1, 32'h0, 32'h0000_C0DE);
    wait_ack(1, t1);
    drop(1);
    chk("t4_oor_sticky", 32'(oor_err), 1);

    // 5: reset during WAIT of a P read
    p_rd_req = 1; p_addr = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 0;
    p_rd_req = 0;
    @(posedge clk); #1;
    rstn = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_ack", {30'd0, p_rd_ack, p_wr_ack}, 0);
    end
    chk("t5_cs", 32'(sram_cs), 0);
    chk("t5_oor", 32'(oor_err), 0);
    chk("t5_p_rdata", p_rdata, 0);
    @(posedge clk); #1;
    t0 = cyc;
    start(0, 0, 32'h10, 0);
    wait_ack(0, t1);
    drop(0);
    chk("t5_after_latency", 32'(t1 - t0), 3);

    // 6: 16 back-to-back P writes against continuous C reads of word 0
    p_done = 0;
    p_ack_cnt = 0;
    alt_prev_valid = 0;
    alt_on = 1;
    fork
      begin : t6_p
        int tp;
        for (int i = 0; i < 16; i++) begin
          start(0, 1, 32'(i), (i == 0) ? 32'h0000_C0DE : 32'hB000_0000 + 32'(i));
          wait_ack(0, tp);
        end
        drop(0);
        p_done = 1;
      end
      begin : t6_c
        int tc;
        start(1, 0, 32'h0, 0);
        wait_ack(1, tc);
        while (!p_done) begin
          start(1, 0, 32'h0, 0);
          wait_ack(1, tc);
        end
        drop(1);
      end
    join
    alt_on = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_p_acks", 32'(p_ack_cnt), 16);
    chk("t6_p_q_empty", 32'(p_q.size()), 0);
    chk("t6_c_q_empty", 32'(c_q.size()), 0);
    chk("t6_last_word", mem[15], 32'hB000_000F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
